// File: rtl/pipe_chain_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the pipe_chain register pipeline.
//
// Contents:
//   WORD_WIDTH  default payload width of one pipeline stage
//   CNT_WIDTH   width of the optional performance counters
//   ctrl_e      per-cycle control mode, listed from highest to lowest priority
//   ctrl_decode collapses freeze/flush/stall into one ctrl_e value
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int WORD_WIDTH = 64;
    localparam int CNT_WIDTH  = 32;

    // Control encoding. The order of the decode below is the priority order.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2,
        ADV   = 2'd3
    } ctrl_e;

    function automatic ctrl_e ctrl_decode(input logic freeze,
                                          input logic flush,
                                          input logic stall);
        ctrl_e mode;
        if (freeze) begin
            mode = HOLD;
        end else if (flush) begin
            mode = FLUSH;
        end else if (stall) begin
            mode = STALL;
        end else begin
            mode = ADV;
        end
        return mode;
    endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// ---------------------------------------------------------------------------
// pipe_chain_if -- bus between a producer/controller and the pipe_chain.
//
// Handshake: in_ready = !freeze && !stall, and is combinational. An item on
// in_data is taken at a rising clk edge only when in_valid && in_ready && !flush
// all hold at that edge. The output side has no back-pressure: out_valid marks
// a valid item in the last stage and it moves on at the next non-frozen edge.
//
// Signals:
//   in_valid, in_data        item offered to stage 0
//   freeze, flush, stall     pipeline controls (freeze > flush > stall)
//   in_ready                 pipeline can take an item this cycle
//   out_valid, out_data      last stage contents
//   stage_valid              valid bit of every stage (bit s = stage s)
//
// Modports: master drives items/controls, slave is the pipeline itself.
// ---------------------------------------------------------------------------
interface pipe_chain_if #(
    parameter int WIDTH  = pipe_pkg::WORD_WIDTH,
    parameter int STAGES = 4
);

    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              freeze;
    logic              flush;
    logic              stall;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [STAGES-1:0] stage_valid;

    modport master (
        output in_valid, in_data, freeze, flush, stall,
        input  in_ready, out_valid, out_data, stage_valid
    );

    modport slave (
        input  in_valid, in_data, freeze, flush, stall,
        output in_ready, out_valid, out_data, stage_valid
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg -- one pipeline stage: a valid bit plus WIDTH bits of data.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              take {d_valid, d_data}
//   clear             drop the valid bit, keep the data
//   d_valid, d_data   next contents when loading
//   q_valid, q_data   current contents
// With neither load nor clear the stage holds. clear wins over load.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (clear) begin
            // Invalidating a stage leaves the payload untouched.
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// ---------------------------------------------------------------------------
// pipe_chain -- STAGES-deep register pipeline with freeze, flush and stall.
//
// Parameters:
//   WIDTH         payload bits per stage
//   STAGES        number of stages (2..16)
//   FLUSH_STAGES  leading stages invalidated by flush (1..STAGES)
//   STALL_STAGE   first stage that gets a bubble on stall (1..STAGES-1)
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           pipe_chain_if.slave (items in/out, controls, stage_valid)
//
// Optional feature, enabled by defining PIPE_CHAIN_PERF_EN:
//   cnt_clr       synchronous clear of both counters, wins over increment
//   bubble_cnt    number of effective stall cycles (wraps)
//   flush_cnt     number of effective flush cycles (wraps)
//
// Per cycle the mode is HOLD (freeze), FLUSH, STALL or ADV, in that priority.
//   ADV   : every stage loads its predecessor, stage 0 loads the input.
//   FLUSH : stages 0..FLUSH_STAGES-1 are invalidated and the input is dropped;
//           stage FLUSH_STAGES takes a bubble, stages above advance.
//   STALL : stages below STALL_STAGE hold, STALL_STAGE takes a bubble,
//           stages above advance.
//   HOLD  : nothing changes.
// ---------------------------------------------------------------------------
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH        = WORD_WIDTH,
    parameter int STAGES       = 4,
    parameter int FLUSH_STAGES = 2,
    parameter int STALL_STAGE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_chain_if.slave          bus
`ifdef PIPE_CHAIN_PERF_EN
    ,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    // Reject parameter sets the pipeline cannot implement.
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_chain: WIDTH must be at least 1");
    end
    if (STAGES < 2 || STAGES > 16) begin : g_bad_stages
        $error("pipe_chain: STAGES must be in 2..16");
    end
    if (FLUSH_STAGES < 1 || FLUSH_STAGES > STAGES) begin : g_bad_flush
        $error("pipe_chain: FLUSH_STAGES must be in 1..STAGES");
    end
    if (STALL_STAGE < 1 || STALL_STAGE > STAGES - 1) begin : g_bad_stall
        $error("pipe_chain: STALL_STAGE must be in 1..STAGES-1");
    end

    ctrl_e             mode;
    logic [STAGES-1:0] s_valid;
    logic [WIDTH-1:0]  s_data [STAGES];

    assign mode = ctrl_decode(bus.freeze, bus.flush, bus.stall);

    assign bus.in_ready    = !bus.freeze && !bus.stall;
    assign bus.out_valid   = s_valid[STAGES-1];
    assign bus.out_data    = s_data[STAGES-1];
    assign bus.stage_valid = s_valid;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             ld;
        logic             clr;
        logic             d_valid;
        logic [WIDTH-1:0] d_data;

        if (s == 0) begin : g_head
            assign d_valid = bus.in_valid;
            assign d_data  = bus.in_data;
        end else begin : g_body
            assign d_valid = s_valid[s-1];
            assign d_data  = s_data[s-1];
        end

        always_comb begin
            ld  = 1'b0;
            clr = 1'b0;
            case (mode)
                HOLD: begin
                    ld  = 1'b0;
                    clr = 1'b0;
                end
                FLUSH: begin
                    // Stage FLUSH_STAGES is the bubble slot: it would have
                    // received the flushed stage's item, so it goes invalid.
                    if (s <= FLUSH_STAGES) begin
                        clr = 1'b1;
                    end else begin
                        ld = 1'b1;
                    end
                end
                STALL: begin
                    if (s == STALL_STAGE) begin
                        clr = 1'b1;
                    end else if (s > STALL_STAGE) begin
                        ld = 1'b1;
                    end
                end
                ADV: begin
                    ld = 1'b1;
                end
                default: begin
                    ld  = 1'b0;
                    clr = 1'b0;
                end
            endcase
        end

        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (ld),
            .clear   (clr),
            .d_valid (d_valid),
            .d_data  (d_data),
            .q_valid (s_valid[s]),
            .q_data  (s_data[s])
        );
    end

`ifdef PIPE_CHAIN_PERF_EN
    // Counters only see effective controls, so a frozen cycle never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (mode == STALL) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (mode == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_chain -- self-checking bench for pipe_chain (WIDTH=8, STAGES=4,
// FLUSH_STAGES=2, STALL_STAGE=2). Inputs change 1 time unit after a falling
// edge; outputs are looked at on falling edges. Accepted items go into
// exp_q and are popped when they arrive in the last stage.
// Define PIPE_CHAIN_PERF_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_pipe_chain;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int FS = 2;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_chain_if #(.WIDTH(W), .STAGES(N)) bus ();

`ifdef PIPE_CHAIN_PERF_EN
    logic        cnt_clr = 1'b0;
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_chain #(
        .WIDTH        (W),
        .STAGES       (N),
        .FLUSH_STAGES (FS),
        .STALL_STAGE  (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef PIPE_CHAIN_PERF_EN
        ,
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    int exp_bubble = 0;
    int exp_flush  = 0;

    // ---------------- driver tasks ----------------
    // Present one cycle of stimulus, then wait until the edge has passed.
    task automatic tick(input logic v, input logic [W-1:0] d,
                        input logic fr, input logic fl, input logic st);
        #1;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.freeze   = fr;
        bus.flush    = fl;
        bus.stall    = st;
        if (v && !fr && !fl && !st) exp_q.push_back(d);
        if (!fr && fl) exp_flush++;
        else if (!fr && st) exp_bubble++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill(input logic [W-1:0] first);
        for (int i = 0; i < N; i++) tick(1'b1, first + W'(i), 1'b0, 1'b0, 1'b0);
    endtask

`ifdef PIPE_CHAIN_PERF_EN
    task automatic clear_counters();
        #1;
        cnt_clr = 1'b1;
        @(negedge clk);
        #1;
        cnt_clr = 1'b0;
        exp_bubble = 0;
        exp_flush  = 0;
    endtask
`endif

    // ---------------- scoreboard monitor ----------------
    task automatic monitor_loop();
        logic adv;
        logic [W-1:0] exp;
        forever begin
            @(posedge clk);
            adv = !bus.freeze && !rst;
            @(negedge clk);
            if (adv && bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got item %h, required no item", bus.out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.out_data !== exp) begin
                        errors++;
                        $display("FAIL sb_order: got %h, required %h", bus.out_data, exp);
                    end
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if (bus.stage_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0000", bus.stage_valid);
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", bus.in_ready);
        end
`ifdef PIPE_CHAIN_PERF_EN
        checks++;
        if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d, required 0/0", bubble_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic ev;
        for (int t = 1; t <= 12; t++) begin
            tick(t <= 8, W'(t), 1'b0, 1'b0, 1'b0);
            ev = (t >= 4) && (t <= 11);
            checks++;
            if (bus.out_valid !== ev) begin
                errors++;
                $display("FAIL stream_valid t=%0d: got %b, required %b", t, bus.out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (bus.out_data !== W'(t - 3)) begin
                    errors++;
                    $display("FAIL stream_data t=%0d: got %h, required %h", t, bus.out_data, W'(t - 3));
                end
            end
        end
    endtask

    task automatic test_freeze();
        fill(8'h31);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'h35, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.stage_valid !== 4'b1111 || bus.out_data !== 8'h31 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold c=%0d: got valid=%b data=%h ready=%b, required 1111 31 0",
                         i, bus.stage_valid, bus.out_data, bus.in_ready);
            end
        end
        idle(6);
    endtask

    task automatic test_stall();
        logic [N-1:0] seq_v [4];
        logic [W-1:0] seq_d [4];
        seq_v = '{1'b1, 1'b0, 1'b1, 1'b1};
        seq_d = '{8'h12, 8'h00, 8'h13, 8'h14};
        fill(8'h11);
        tick(1'b1, 8'h15, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.stage_valid !== 4'b1011) begin
            errors++;
            $display("FAIL stall_valid: got %b, required 1011", bus.stage_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== seq_v[i][0] || (seq_v[i][0] && bus.out_data !== seq_d[i])) begin
                errors++;
                $display("FAIL stall_seq i=%0d: got %b/%h, required %b/%h",
                         i, bus.out_valid, bus.out_data, seq_v[i][0], seq_d[i]);
            end
            tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
`ifdef PIPE_CHAIN_PERF_EN
        checks++;
        if (bubble_cnt !== 32'(exp_bubble)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required %0d", bubble_cnt, exp_bubble);
        end
`endif
        idle(4);
    endtask

    task automatic test_flush();
`ifdef PIPE_CHAIN_PERF_EN
        clear_counters();
`endif
        fill(8'h21);
        // Stages 0 and 1 hold the two newest items; the flush drops them.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        tick(1'b1, 8'h25, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.stage_valid !== 4'b1000 || bus.out_data !== 8'h22) begin
            errors++;
            $display("FAIL flush_state: got %b/%h, required 1000/22", bus.stage_valid, bus.out_data);
        end
`ifdef PIPE_CHAIN_PERF_EN
        checks++;
        if (flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL flush_cnt: got %0d, required 1", flush_cnt);
        end
`endif
        idle(6);
    endtask

    task automatic test_freeze_priority();
`ifdef PIPE_CHAIN_PERF_EN
        clear_counters();
`endif
        fill(8'h41);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 8'h45, 1'b1, 1'b1, 1'b1);
            checks++;
            if (bus.stage_valid !== 4'b1111 || bus.out_data !== 8'h41) begin
                errors++;
                $display("FAIL prio_freeze c=%0d: got %b/%h, required 1111/41", i, bus.stage_valid, bus.out_data);
            end
        end
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        tick(1'b1, 8'h46, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.stage_valid !== 4'b1000 || bus.out_data !== 8'h42) begin
            errors++;
            $display("FAIL prio_flush: got %b/%h, required 1000/42", bus.stage_valid, bus.out_data);
        end
`ifdef PIPE_CHAIN_PERF_EN
        checks++;
        if (bubble_cnt !== 32'(exp_bubble) || flush_cnt !== 32'(exp_flush)) begin
            errors++;
            $display("FAIL prio_cnt: got %0d/%0d, required %0d/%0d", bubble_cnt, flush_cnt, exp_bubble, exp_flush);
        end
`endif
        idle(6);
    endtask

    task automatic test_async_reset();
        tick(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h53, 1'b0, 1'b0, 1'b0);
        #1;
        bus.stall  = 1'b1;
        bus.freeze = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_bubble = 0;
        exp_flush  = 0;
        checks++;
        if (bus.stage_valid !== 4'b0000 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b/%h, required 0000/00", bus.stage_valid, bus.out_data);
        end
        bus.stall  = 1'b0;
        bus.freeze = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        idle(6);
        checks++;
        if (bus.stage_valid !== 4'b0000) begin
            errors++;
            $display("FAIL async_release: got %b, required 0000", bus.stage_valid);
        end
    endtask

    task automatic test_random();
        logic v, fr, st;
        logic [W-1:0] d;
        int r;
        for (int i = 0; i < 150; i++) begin
            v  = 1'($urandom_range(0, 1));
            d  = W'($urandom_range(0, 255));
            r  = $urandom_range(0, 7);
            fr = (r == 0);
            st = (r == 1);
            tick(v, d, fr, 1'b0, st);
            checks++;
            if (bus.in_ready !== !(fr || st)) begin
                errors++;
                $display("FAIL rand_ready i=%0d: got %b, required %b", i, bus.in_ready, !(fr || st));
            end
        end
        idle(8);
    endtask

    task automatic test_drain();
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d items left, required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.freeze   = 1'b0;
        bus.flush    = 1'b0;
        bus.stall    = 1'b0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_stream();
        test_freeze();
        test_stall();
        test_flush();
        test_freeze_priority();
        test_async_reset();
        test_random();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
